// File: rtl/wb_b3_burst_master.sv
// Wishbone B3 initiator: turns one command into a linear incrementing burst.
// Latency: cyc rises the cycle after command accept; read data 1 cycle after ack; done/err 1 cycle after the last response.
// Backpressure: cmd_ready_o only in IDLE; missing write word lowers stb; no read backpressure.
module wb_b3_burst_master #(
  parameter int dw             = 32,
  parameter int aw             = 32,
  parameter int timeout_cycles = 255
) (
  input  logic          wb_clk_i,
  input  logic          wb_rst_i,
  input  logic          cmd_valid_i,
  output logic          cmd_ready_o,
  input  logic [aw-1:0] cmd_adr_i,
  input  logic [4:0]    cmd_len_i,
  input  logic          cmd_we_i,
  input  logic [dw-1:0] wr_dat_i,
  input  logic          wr_valid_i,
  output logic          wr_ready_o,
  output logic [dw-1:0] rd_dat_o,
  output logic          rd_valid_o,
  output logic          busy_o,
  output logic          done_o,
  output logic          err_o,
  output logic [aw-1:0] wb_adr_o,
  output logic [dw-1:0] wb_dat_o,
  output logic [3:0]    wb_sel_o,
  output logic          wb_we_o,
  output logic [1:0]    wb_bte_o,
  output logic [2:0]    wb_cti_o,
  output logic          wb_cyc_o,
  output logic          wb_stb_o,
  input  logic          wb_ack_i,
  input  logic          wb_err_i,
  input  logic          wb_rty_i,
  input  logic [dw-1:0] wb_dat_i
);

  typedef enum logic [1:0] {IDLE, BUS, RETRY} state_t;

  localparam logic [7:0] wd_last = 8'(timeout_cycles - 1);
  localparam bit         wd_en   = (timeout_cycles != 0);

  state_t        state, state_nxt;
  logic [aw-1:0] adr_q;
  logic [4:0]    rem_q;
  logic          we_q;
  logic          classic_q;   // single-beat cycle: either len 1, or a retry left one beat
  logic [7:0]    wd_cnt;
  logic          stb;
  logic          stall;
  logic          ack_hit;
  logic          err_hit;
  logic          rty_hit;
  logic          tmo_hit;

  // State register
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) state <= IDLE;
    else          state <= state_nxt;
  end

  // Next state, bus control and response decode (err beats ack, ack beats rty)
  always_comb begin
    state_nxt   = state;
    cmd_ready_o = 1'b0;
    wb_cyc_o    = 1'b0;
    stb         = 1'b0;
    wb_we_o     = 1'b0;
    wb_sel_o    = 4'h0;
    wb_cti_o    = 3'b000;
    stall       = 1'b0;
    tmo_hit     = 1'b0;
    err_hit     = 1'b0;
    ack_hit     = 1'b0;
    rty_hit     = 1'b0;
    case (state)
      IDLE: begin
        cmd_ready_o = 1'b1;
        if (cmd_valid_i) state_nxt = BUS;
      end
      BUS: begin
        wb_cyc_o = 1'b1;
        stb      = we_q ? wr_valid_i : 1'b1;
        wb_we_o  = we_q;
        wb_sel_o = 4'hf;
        wb_cti_o = classic_q ? 3'b000 : ((rem_q == 5'd1) ? 3'b111 : 3'b010);
        stall    = stb && !wb_ack_i && !wb_err_i && !wb_rty_i;
        tmo_hit  = wd_en && stall && (wd_cnt == wd_last);
        err_hit  = stb && (wb_err_i || tmo_hit);
        ack_hit  = stb && wb_ack_i && !wb_err_i;
        rty_hit  = stb && wb_rty_i && !wb_ack_i && !wb_err_i;
        if (err_hit)                           state_nxt = IDLE;
        else if (ack_hit && rem_q == 5'd1)     state_nxt = IDLE;
        else if (rty_hit)                      state_nxt = RETRY;
      end
      RETRY:   state_nxt = BUS;
      default: state_nxt = IDLE;
    endcase
  end

  assign wb_stb_o   = stb;
  assign wb_adr_o   = adr_q;
  assign wb_dat_o   = (state == BUS && we_q) ? wr_dat_i : '0;
  assign wb_bte_o   = 2'b00;
  assign wr_ready_o = ack_hit && we_q;
  assign busy_o     = (state != IDLE);

  // Command capture, beat accounting, read capture, status pulses and watchdog
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      adr_q      <= '0;
      rem_q      <= '0;
      we_q       <= 1'b0;
      classic_q  <= 1'b0;
      wd_cnt     <= '0;
      rd_dat_o   <= '0;
      rd_valid_o <= 1'b0;
      done_o     <= 1'b0;
      err_o      <= 1'b0;
    end else begin
      rd_valid_o <= 1'b0;
      done_o     <= 1'b0;
      err_o      <= 1'b0;
      if (state == IDLE && cmd_valid_i) begin
        adr_q     <= cmd_adr_i & ~aw'(3);
        rem_q     <= (cmd_len_i == 5'd0) ? 5'd1 : cmd_len_i;
        we_q      <= cmd_we_i;
        classic_q <= (cmd_len_i <= 5'd1);
      end
      if (ack_hit) begin
        adr_q <= adr_q + aw'(4);
        rem_q <= rem_q - 5'd1;
        if (!we_q) begin
          rd_dat_o   <= wb_dat_i;
          rd_valid_o <= 1'b1;
        end
        if (rem_q == 5'd1) done_o <= 1'b1;
      end
      if (err_hit) err_o <= 1'b1;
      // Re-entry with one beat left is issued as a classic cycle
      if (rty_hit) classic_q <= (rem_q == 5'd1);
      if (stall) wd_cnt <= wd_cnt + 8'd1;
      else       wd_cnt <= 8'd0;
    end
  end

endmodule

// File: tb/tb_wb_b3_burst_master.sv
// Randomized bench for wb_b3_burst_master with a scripted Wishbone RAM slave and a command-level reference model.
// Each command's expected beats, addresses, cti, data and outcome are derived up front from the command and slave plan.
// The slave script decides wait states, err, rty and silent (timeout) beats per command.
module tb_wb_b3_burst_master;

  localparam int TMO = 5;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid, cmd_ready, cmd_we;
  logic [31:0] cmd_adr;
  logic [4:0]  cmd_len;
  logic [31:0] wr_dat, rd_dat;
  logic        wr_valid, wr_ready, rd_valid;
  logic        busy, done, abort;
  logic [31:0] wb_adr, wb_dat;
  logic [3:0]  wb_sel;
  logic        wb_we, wb_cyc, wb_stb;
  logic [1:0]  wb_bte;
  logic [2:0]  wb_cti;
  logic        ack, berr, rty;
  logic [31:0] bdat_in;

  logic [31:0] ram [256];
  logic [31:0] model_mem [256];
  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  wb_b3_burst_master #(.dw(32), .aw(32), .timeout_cycles(TMO)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_adr_i(cmd_adr),
    .cmd_len_i(cmd_len), .cmd_we_i(cmd_we),
    .wr_dat_i(wr_dat), .wr_valid_i(wr_valid), .wr_ready_o(wr_ready),
    .rd_dat_o(rd_dat), .rd_valid_o(rd_valid),
    .busy_o(busy), .done_o(done), .err_o(abort),
    .wb_adr_o(wb_adr), .wb_dat_o(wb_dat), .wb_sel_o(wb_sel), .wb_we_o(wb_we),
    .wb_bte_o(wb_bte), .wb_cti_o(wb_cti), .wb_cyc_o(wb_cyc), .wb_stb_o(wb_stb),
    .wb_ack_i(ack), .wb_err_i(berr), .wb_rty_i(rty), .wb_dat_i(bdat_in)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, got, want);
    end
  endtask

  function automatic int widx(input logic [31:0] a);
    return int'(a[9:2]);
  endfunction

  // cti of acked beat k: classic for a 1-beat command or for a last beat re-issued after a retry
  function automatic logic [2:0] exp_cti(input int k, input int n, input int rty_beat);
    if (n == 1) return 3'b000;
    if (k == n - 1) return (rty_beat == n - 1) ? 3'b000 : 3'b111;
    return 3'b010;
  endfunction

  task automatic run_cmd(input logic [31:0] adr, input int len_in, input bit we,
                         input int err_beat, input int rty_beat, input int hang_beat);
    int n, n_ok, sk, mk, rk, wr_cnt, done_cnt, err_cnt, end_cyc, fin_cyc, acc_cyc, stall, wi, waitc, rp;
    bit ok, sent, rty_done;
    logic [31:0] base;
    logic [31:0] wdat [16];
    logic [31:0] exp_rd [16];
    n    = (len_in == 0) ? 1 : len_in;
    base = adr & 32'hFFFF_FFFC;
    n_ok = n;
    ok   = 1'b1;
    if (err_beat >= 0 && err_beat < n)   begin n_ok = err_beat; ok = 1'b0; end
    if (hang_beat >= 0 && hang_beat < n && hang_beat < n_ok) begin n_ok = hang_beat; ok = 1'b0; end
    for (int k = 0; k < 16; k++) begin
      wdat[k]   = $urandom;
      exp_rd[k] = model_mem[widx(base + 32'(4 * k))];
    end
    sk = 0; mk = 0; rk = 0; wr_cnt = 0; done_cnt = 0; err_cnt = 0; wi = 0; waitc = 0; rp = 0;
    end_cyc = -1; fin_cyc = -1; acc_cyc = -1; stall = 0; sent = 1'b0; rty_done = 1'b0;
    for (int c = 0; c < 400 && fin_cyc < 0; c++) begin
      @(posedge clk); #1;
      cmd_valid = !sent; cmd_adr = adr; cmd_len = 5'(len_in); cmd_we = we;
      wr_valid  = we && (wi < n) && ($urandom_range(0, 3) != 0);
      wr_dat    = wr_valid ? wdat[wi] : $urandom;
      ack = 1'b0; berr = 1'b0; rty = 1'b0; bdat_in = $urandom;
      #1;
      if (wb_cyc && wb_stb) begin
        if (sk == hang_beat) begin
        end else if (waitc > 0) begin
          waitc--;
        end else if (sk == err_beat) begin
          berr = 1'b1;
        end else if (sk == rty_beat && !rty_done) begin
          rty = 1'b1; rty_done = 1'b1;
        end else begin
          ack = 1'b1;
          bdat_in = ram[widx(wb_adr)];
          if (wb_we) ram[widx(wb_adr)] = wb_dat;
          sk++;
          waitc = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 2)) : 0;
        end
      end
      #2;
      if (!sent && cmd_valid && cmd_ready) begin sent = 1'b1; acc_cyc = c; end
      if (acc_cyc >= 0 && c == acc_cyc + 1) check("cyc_start", {31'd0, wb_cyc}, 32'd1);
      if (ack) begin
        check("adr", wb_adr, base + 32'(4 * mk));
        check("cti", {29'd0, wb_cti}, {29'd0, exp_cti(mk, n, rty_beat)});
        check("sel", {28'd0, wb_sel}, 32'hf);
        check("bte", {30'd0, wb_bte}, 32'd0);
        check("we", {31'd0, wb_we}, {31'd0, we});
        if (we) begin
          check("wr_ready", {31'd0, wr_ready}, 32'd1);
          check("wdat", wb_dat, wdat[mk]);
        end
        mk++;
        if (mk == n) end_cyc = c;
        stall = 0;
      end else if (berr || rty) begin
        stall = 0;
        if (berr) end_cyc = c;
      end else if (wb_cyc && wb_stb) begin
        stall++;
        if (stall == TMO) end_cyc = c;
      end else begin
        stall = 0;
      end
      if (wr_ready) begin wr_cnt++; wi++; end
      if (rd_valid) begin
        if (rk < 16) check("rdat", rd_dat, exp_rd[rk]);
        rk++;
      end
      if (rp == 1) begin check("rty_gap", {31'd0, wb_cyc}, 32'd0); rp = 2; end
      else if (rp == 2) begin check("rty_resume", {31'd0, wb_cyc}, 32'd1); rp = 0; end
      if (rty) rp = 1;
      if (done || abort) begin
        fin_cyc = c;
        if (done) done_cnt++;
        if (abort) err_cnt++;
        check("end_time", c, end_cyc + 1);
        check("cyc_drop", {31'd0, wb_cyc}, 32'd0);
        check("ready_back", {31'd0, cmd_ready}, 32'd1);
      end
    end
    cmd_valid = 1'b0; wr_valid = 1'b0; ack = 1'b0; berr = 1'b0; rty = 1'b0;
    check("finished", {31'd0, fin_cyc >= 0}, 32'd1);
    check("beats", mk, n_ok);
    check("done_cnt", done_cnt, {31'd0, ok});
    check("err_cnt", err_cnt, {31'd0, !ok});
    if (we) check("wr_cnt", wr_cnt, n_ok);
    else    check("rd_cnt", rk, n_ok);
    if (we) for (int k = 0; k < n_ok; k++) model_mem[widx(base + 32'(4 * k))] = wdat[k];
    for (int k = 0; k < n; k++)
      check("mem", ram[widx(base + 32'(4 * k))], model_mem[widx(base + 32'(4 * k))]);
  endtask

  task automatic reset_mid_burst();
    int dn, er, rv;
    dn = 0; er = 0; rv = 0;
    @(posedge clk); #1;
    cmd_valid = 1'b1; cmd_adr = 32'h40; cmd_len = 5'd16; cmd_we = 1'b0;
    wr_valid = 1'b0; berr = 1'b0; rty = 1'b0; ack = 1'b1; bdat_in = $urandom;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    repeat (4) begin @(posedge clk); #1; bdat_in = $urandom; end
    #3 check("mid_cyc", {31'd0, wb_cyc}, 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; ack = 1'b0;
    #3;
    check("rst_cyc", {31'd0, wb_cyc}, 32'd0);
    check("rst_stb", {31'd0, wb_stb}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_ready", {31'd0, cmd_ready}, 32'd1);
    check("rst_cti", {29'd0, wb_cti}, 32'd0);
    check("rst_adr", wb_adr, 32'd0);
    repeat (6) begin
      @(posedge clk); #4;
      if (done) dn++;
      if (abort) er++;
      if (rd_valid) rv++;
    end
    check("rst_no_done", dn, 0);
    check("rst_no_err", er, 0);
    check("rst_no_rd", rv, 0);
  endtask

  initial begin
    int r, eb, rb, hb;
    cmd_valid = 1'b0; cmd_adr = '0; cmd_len = '0; cmd_we = 1'b0;
    wr_dat = '0; wr_valid = 1'b0; ack = 1'b0; berr = 1'b0; rty = 1'b0; bdat_in = '0;
    for (int i = 0; i < 256; i++) begin ram[i] = $urandom; model_mem[i] = ram[i]; end
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #4;
    check("reset_ready", {31'd0, cmd_ready}, 32'd1);
    check("reset_cyc", {31'd0, wb_cyc}, 32'd0);
    check("reset_stb", {31'd0, wb_stb}, 32'd0);
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_done", {31'd0, done}, 32'd0);
    check("reset_err", {31'd0, abort}, 32'd0);
    check("reset_rdv", {31'd0, rd_valid}, 32'd0);
    check("reset_wrr", {31'd0, wr_ready}, 32'd0);
    check("reset_cti", {29'd0, wb_cti}, 32'd0);
    check("reset_we", {31'd0, wb_we}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    run_cmd(32'h100, 4, 1'b0, -1, -1, -1);
    run_cmd(32'h200, 1, 1'b1, -1, -1, -1);
    run_cmd(32'h200, 1, 1'b0, -1, -1, -1);
    run_cmd(32'h000, 8, 1'b1, -1, -1, -1);
    run_cmd(32'h000, 8, 1'b0, -1, -1, -1);
    run_cmd(32'h300, 4, 1'b0, 2, -1, -1);
    run_cmd(32'h300, 4, 1'b0, -1, 1, -1);
    run_cmd(32'h300, 4, 1'b0, -1, -1, 0);
    run_cmd(32'h304, 4, 1'b1, -1, 3, -1);
    run_cmd(32'hFFFF_FFFA, 4, 1'b1, -1, -1, -1);
    run_cmd(32'h050, 0, 1'b0, -1, -1, -1);
    run_cmd(32'h080, 16, 1'b1, -1, -1, -1);
    for (int i = 0; i < 60; i++) begin
      r  = int'($urandom_range(0, 9));
      eb = (r == 0) ? int'($urandom_range(0, 15)) : -1;
      rb = (r == 1 || r == 2) ? int'($urandom_range(0, 15)) : -1;
      hb = (r == 3) ? int'($urandom_range(0, 15)) : -1;
      run_cmd($urandom, int'($urandom_range(0, 16)), 1'($urandom_range(0, 1)), eb, rb, hb);
    end
    reset_mid_burst();
    run_cmd(32'h100, 4, 1'b0, -1, -1, -1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/wb_b3_burst_master.md
Name: wb_b3_burst_master

Overview:
- Wishbone B3 initiator that turns single commands into linear incrementing bursts.
- Each command carries an address, a beat count and a direction. The block drives one bus cycle and moves data through a simple write-stream input and a read-stream output.
- It sits between DMA/test engines and on-chip RAM slaves on the same bus; its primary target is the B3 RAM slave.

Parameters:
- dw, 32, data width in bits (only 32 supported).
- aw, 32, address width in bits.
- timeout_cycles, 255, maximum number of cycles the block waits for a response with stb high before it aborts (8-bit counter; 0 disables the watchdog).

Ports:
- wb_clk_i  in  1  clock
- wb_rst_i  in  1  synchronous active-high reset
- cmd_valid_i  in  1  command present
- cmd_ready_o  out  1  command accepted when valid & ready
- cmd_adr_i  in  aw  byte start address; bits [1:0] ignored
- cmd_len_i  in  5  beat count, 1..16 (0 is treated as 1)
- cmd_we_i  in  1  1 = write, 0 = read
- wr_dat_i  in  dw  write data for the current beat
- wr_valid_i  in  1  write data present
- wr_ready_o  out  1  current write word consumed this cycle
- rd_dat_o  out  dw  read data
- rd_valid_o  out  1  one-cycle strobe, rd_dat_o valid
- busy_o  out  1  command in progress
- done_o  out  1  one-cycle pulse: command completed OK
- err_o  out  1  one-cycle pulse: command aborted (wb_err_i or timeout)
- wb_adr_o  out  aw  bus address
- wb_dat_o  out  dw  bus write data
- wb_sel_o  out  4  byte selects, always 4'hf
- wb_we_o  out  1  write enable
- wb_bte_o  out  2  always 2'b00 (linear)
- wb_cti_o  out  3  cycle type
- wb_cyc_o  out  1  cycle
- wb_stb_o  out  1  strobe
- wb_ack_i  in  1  acknowledge
- wb_err_i  in  1  error
- wb_rty_i  in  1  retry
- wb_dat_i  in  dw  bus read data

Behaviour:
- Reset values: all outputs 0 except cmd_ready_o = 1. Reset mid-burst drops cyc/stb on the next edge, discards the command and emits no done_o or err_o.
- States: IDLE, BUS, RETRY.
- IDLE:
  - cmd_ready_o = 1.
  - On cmd_valid_i, register {adr[aw-1:2],2'b00}, remaining = len (0→1) and we, then go to BUS.
  - cmd_ready_o is 0 in every other state.
- BUS:
  - wb_cyc_o = 1.
  - wb_stb_o = 1 for reads; for writes wb_stb_o = wr_valid_i, so a missing write word becomes a stb-low wait state.
  - wb_dat_o = wr_dat_i, combinational.
  - wb_adr_o = registered current address.
- cti selection:
  - len == 1: 3'b000 (classic).
  - Otherwise 3'b010 while remaining > 1, and 3'b111 on the final beat.
  - Computed from registered state, so it is stable while stb is high.
- On each wb_ack_i with stb high:
  - address += 4, with wrap at 2^aw; remaining -= 1.
  - Write: wr_ready_o = 1 in the same cycle, combinational from the ack.
  - Read: rd_dat_o <= wb_dat_i and rd_valid_o = 1 on the following cycle (latency 1). There is no read backpressure.
- Final beat ack: cyc and stb drop on the next edge, state goes to IDLE, and done_o pulses in that next cycle. There are no idle cycles between beats unless the slave inserts them.
- wb_err_i (priority over ack in the same cycle):
  - Drop cyc/stb, pulse err_o and go to IDLE.
  - Address and remaining freeze; the beat is not counted, and no wr_ready_o or rd_valid_o is issued for it.
- wb_rty_i (when ack and err are low):
  - Drop cyc/stb and go to RETRY for exactly 1 cycle.
  - Then re-enter BUS at the current address with the current remaining count; cti is recomputed (remaining == 1 uses classic 000).
- Watchdog:
  - Counts cycles in BUS with stb high and no ack/err/rty; it resets on any response or on stb low.
  - On reaching timeout_cycles, behave as wb_err_i.
- busy_o = (state != IDLE).

Test Plan:
1. Read, adr 0x100, len 4, slave acks every cycle → cti 010,010,010,111; adr 0x100/104/108/10C; 4 rd_valid_o strobes with the RAM contents; done_o one cycle after the last ack; cyc low for 1 cycle before the next command can issue.
2. Write, adr 0x200, len 1 → cti 000, sel f; one ack, wr_ready_o high in the ack cycle; done_o 1 cycle later; readback returns the written word.
3. Write, len 8, wr_valid_i low for 3 cycles after beat 2 → stb low for those 3 cycles with cyc held high; 8 acks total; address sequence continuous 0x0..0x1C.
4. Read, len 4, slave asserts err on beat 3 (adr out of range) → err_o pulses; only 2 rd_valid_o strobes; no done_o; next command accepted.
5. Read, len 4, rty on beat 2 → one cycle with cyc low, then resumes at adr+4 with remaining 3 (cti 010,010,111); 4 rd_valid_o total; done_o.
6. timeout_cycles = 5, slave never acks → err_o after 5 cycles with stb high; cyc drops. Separately, reset asserted mid-burst → all outputs at reset values the next cycle, no done_o/err_o.
